output_port_vc_controller: RTL and testbench

OUTPUT_PORT_VC_CONTROLLER -- requirements
Module: output_port_vc_controller

---
 rtl/output_port_vc_controller_if.sv | 32 +++
 rtl/output_port_vc_controller.sv | 134 +++++++++++++
 tb/tb_output_port_vc_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_port_vc_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : output_port_vc_controller_if
// Brief    : Flit, credit and allocation bundle for one router output port.
// Revision : 1.0 - initial release
// ============================================================================
interface output_port_vc_controller_if #(
  parameter int NUM_VC = 4,
  parameter int DW     = 32,
  parameter int CNT_W  = 4
);
  logic                    valid;
  logic [DW-1:0]           data;
  logic [NUM_VC-1:0]       credit_upd;
  logic [NUM_VC-1:0]       va_claim;
  logic [NUM_VC-1:0]       out_vc_available;
  logic [NUM_VC-1:0]       out_vc_ready;
  logic [NUM_VC*CNT_W-1:0] credit_cnt_flat;
  logic                    err_overflow;
  logic                    err_underflow;

  modport master (
    output valid, data, credit_upd, va_claim,
    input  out_vc_available, out_vc_ready, credit_cnt_flat, err_overflow, err_underflow
  );

  modport slave (
    input  valid, data, credit_upd, va_claim,
    output out_vc_available, out_vc_ready, credit_cnt_flat, err_overflow, err_underflow
  );
endinterface
`default_nettype wire

// File: rtl/output_port_vc_controller.sv
`default_nettype none
// ============================================================================
// Module   : output_port_vc_controller
// Brief    : Per-VC credit counters and ownership FSMs for a router output port.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_vc_controller #(
  parameter int NUM_VC        = 4,
  parameter int VCID_W        = 2,
  parameter int DW            = 32,
  parameter int BUF_DEPTH     = 8,
  parameter int CNT_W         = 4,
  parameter int CREDIT_LBOUND = 0,
  parameter int CREDIT_REG    = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  output_port_vc_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_RESERVED = 2'd1,
    ST_ACTIVE   = 2'd2
  } vc_state_t;

  localparam logic [1:0]       c_type_head     = 2'b00;
  localparam logic [1:0]       c_type_tail     = 2'b10;
  localparam logic [1:0]       c_type_headtail = 2'b11;
  localparam logic [CNT_W-1:0] c_buf_depth     = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] c_lbound        = CNT_W'(CREDIT_LBOUND);

  logic [VCID_W-1:0] w_vcid;
  logic [1:0]        w_type;
  logic              w_unused_payload;
  logic [NUM_VC-1:0] w_cu;
  logic [NUM_VC-1:0] w_ovf;
  logic [NUM_VC-1:0] w_unf;
  logic              r_err_overflow;
  logic              r_err_underflow;

  assign w_vcid           = bus.data[DW-1 -: VCID_W];
  assign w_type           = bus.data[DW-1-VCID_W -: 2];
  assign w_unused_payload = ^bus.data[DW-VCID_W-3:0];

  generate
    if (CREDIT_REG != 0) begin : g_credit_reg
      logic [NUM_VC-1:0] r_credit_upd;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_credit_upd <= '0;
        else       r_credit_upd <= bus.credit_upd;
      end
      assign w_cu = r_credit_upd;
    end else begin : g_credit_direct
      assign w_cu = bus.credit_upd;
    end
  endgenerate

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic             w_send;
    logic             w_release;
    logic             w_ovf_vc;
    logic             w_unf_vc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    vc_state_t        r_state;
    vc_state_t        w_state_nxt;

    // Out-of-range VC ids never equal any i, so they touch no VC.
    assign w_send = bus.valid && (w_vcid == VCID_W'(i));

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_ovf_vc  = 1'b0;
      w_unf_vc  = 1'b0;
      if (w_send && !w_cu[i]) begin
        if (r_cnt == '0) w_unf_vc  = 1'b1;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end else if (w_cu[i] && !w_send) begin
        if (r_cnt == c_buf_depth) w_ovf_vc  = 1'b1;
        else                      w_cnt_nxt = r_cnt + 1'b1;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_release   = 1'b0;
      case (r_state)
        ST_RESERVED: w_release = w_send && (w_type == c_type_headtail);
        ST_ACTIVE:   w_release = w_send && ((w_type == c_type_tail) ||
                                            (w_type == c_type_headtail));
        default:     w_release = 1'b0;
      endcase
      // A claim landing together with the releasing flit re-reserves the VC.
      if (bus.va_claim[i] && ((r_state == ST_FREE) || w_release))
        w_state_nxt = ST_RESERVED;
      else if (w_release)
        w_state_nxt = ST_FREE;
      else if ((r_state == ST_RESERVED) && w_send && (w_type == c_type_head))
        w_state_nxt = ST_ACTIVE;
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_cnt   <= c_buf_depth;
        r_state <= ST_FREE;
      end else begin
        r_cnt   <= w_cnt_nxt;
        r_state <= w_state_nxt;
      end
    end

    assign w_ovf[i]                              = w_ovf_vc;
    assign w_unf[i]                              = w_unf_vc;
    assign bus.out_vc_available[i]               = (r_state == ST_FREE);
    assign bus.out_vc_ready[i]                   = (r_cnt > c_lbound);
    assign bus.credit_cnt_flat[i*CNT_W +: CNT_W] = r_cnt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_err_overflow  <= r_err_overflow  | (|w_ovf);
      r_err_underflow <= r_err_underflow | (|w_unf);
    end
  end

  assign bus.err_overflow  = r_err_overflow;
  assign bus.err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_output_port_vc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_vc_controller
// Brief    : Vector table, corner sequences and random run against a VC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_vc_controller;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  output_port_vc_controller_if #(.NUM_VC(4), .DW(32), .CNT_W(4)) bus4 ();
  output_port_vc_controller_if #(.NUM_VC(3), .DW(32), .CNT_W(4)) bus3 ();

  output_port_vc_controller #(
    .NUM_VC(4), .VCID_W(2), .DW(32), .BUF_DEPTH(8), .CNT_W(4),
    .CREDIT_LBOUND(0), .CREDIT_REG(1)
  ) dut4 (.clk(clk), .rstn(rstn), .bus(bus4));

  output_port_vc_controller #(
    .NUM_VC(3), .VCID_W(2), .DW(32), .BUF_DEPTH(8), .CNT_W(4),
    .CREDIT_LBOUND(0), .CREDIT_REG(0)
  ) dut3 (.clk(clk), .rstn(rstn), .bus(bus3));

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the 4-VC instance: ownership is 0 unowned, 1 granted, 2 mid-packet.
  int m_cnt  [4];
  int m_own  [4];
  bit m_pend [4];
  bit m_ovf, m_unf;

  typedef struct {
    bit         valid;
    int         vc;
    int         ty;
    logic [3:0] cu;
    logic [3:0] claim;
    logic [3:0] e_avail;
    logic [15:0] e_flat;
    bit         e_ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 8; m_own[i] = 0; m_pend[i] = 1'b0;
    end
    m_ovf = 1'b0; m_unf = 1'b0;
  endfunction

  function automatic void model_step(bit v, logic [31:0] d, logic [3:0] cu, logic [3:0] cl);
    int vc, ty;
    bit s, c, ends_pkt;
    vc = int'(d[31:30]);
    ty = int'(d[29:28]);
    for (int i = 0; i < 4; i++) begin
      s = v && (vc == i);
      c = m_pend[i];
      if (s && !c) begin
        if (m_cnt[i] == 0) m_unf = 1'b1; else m_cnt[i] -= 1;
      end else if (c && !s) begin
        if (m_cnt[i] == 8) m_ovf = 1'b1; else m_cnt[i] += 1;
      end
      ends_pkt = s && (((m_own[i] == 1) && (ty == 3)) ||
                       ((m_own[i] == 2) && (ty >= 2)));
      if (cl[i] && ((m_own[i] == 0) || ends_pkt)) m_own[i] = 1;
      else if (ends_pkt)                          m_own[i] = 0;
      else if (s && (m_own[i] == 1) && (ty == 0)) m_own[i] = 2;
      m_pend[i] = cu[i];
    end
  endfunction

  task automatic compare_model();
    logic [3:0]  ea, er;
    logic [15:0] ef;
    for (int i = 0; i < 4; i++) begin
      ea[i] = (m_own[i] == 0);
      er[i] = (m_cnt[i] > 0);
      ef[i*4 +: 4] = 4'(m_cnt[i]);
    end
    check("model_avail", 32'(bus4.out_vc_available), 32'(ea));
    check("model_ready", 32'(bus4.out_vc_ready), 32'(er));
    check("model_cnt",   32'(bus4.credit_cnt_flat), 32'(ef));
    check("model_err",   32'({bus4.err_overflow, bus4.err_underflow}), 32'({m_ovf, m_unf}));
  endtask

  task automatic step(input bit v, input int vc, input int ty,
                      input logic [3:0] cu, input logic [3:0] cl);
    logic [31:0] d;
    d = $urandom;
    d[31:30] = vc[1:0];
    d[29:28] = ty[1:0];
    bus4.valid = v; bus4.data = d; bus4.credit_upd = cu; bus4.va_claim = cl;
    @(posedge clk);
    model_step(v, d, cu, cl);
    @(negedge clk);
    compare_model();
  endtask

  task automatic step3(input bit v, input int vc, input int ty,
                       input logic [2:0] cu, input logic [2:0] cl);
    logic [31:0] d;
    d = $urandom;
    d[31:30] = vc[1:0];
    d[29:28] = ty[1:0];
    bus3.valid = v; bus3.data = d; bus3.credit_upd = cu; bus3.va_claim = cl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus4.valid = 1'b0; bus4.data = '0; bus4.credit_upd = '0; bus4.va_claim = '0;
    bus3.valid = 1'b0; bus3.data = '0; bus3.credit_upd = '0; bus3.va_claim = '0;
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model();
    check("rst_cnt",   32'(bus4.credit_cnt_flat), 32'h8888);
    check("rst_avail", 32'(bus4.out_vc_available), 32'hf);
    check("rst_ready", 32'(bus4.out_vc_ready), 32'hf);
    check("rst_err",   32'({bus4.err_overflow, bus4.err_underflow}), 32'h0);
    rstn = 1'b1;
  endtask

  initial begin
    logic [3:0] cu, cl;
    int r;

    // Types: 0 head, 1 body, 2 tail, 3 head+tail.
    tbl[0] = '{1'b0, 0, 0, 4'b0000, 4'b0010, 4'b1101, 16'h8888, 1'b0};
    tbl[1] = '{1'b1, 1, 0, 4'b0000, 4'b0000, 4'b1101, 16'h8878, 1'b0};
    tbl[2] = '{1'b1, 1, 1, 4'b0000, 4'b0000, 4'b1101, 16'h8868, 1'b0};
    tbl[3] = '{1'b0, 0, 0, 4'b0010, 4'b0000, 4'b1101, 16'h8868, 1'b0};
    tbl[4] = '{1'b0, 0, 0, 4'b0000, 4'b0000, 4'b1101, 16'h8878, 1'b0};
    tbl[5] = '{1'b1, 1, 2, 4'b0000, 4'b0000, 4'b1111, 16'h8868, 1'b0};
    tbl[6] = '{1'b0, 0, 0, 4'b0000, 4'b1001, 4'b0110, 16'h8868, 1'b0};
    tbl[7] = '{1'b1, 0, 3, 4'b0000, 4'b0000, 4'b0111, 16'h8867, 1'b0};
    tbl[8] = '{1'b0, 0, 0, 4'b1000, 4'b0000, 4'b0111, 16'h8867, 1'b0};
    tbl[9] = '{1'b0, 0, 0, 4'b0000, 4'b0000, 4'b0111, 16'h8867, 1'b1};

    do_reset();

    for (int k = 0; k < 10; k++) begin
      step(tbl[k].valid, tbl[k].vc, tbl[k].ty, tbl[k].cu, tbl[k].claim);
      check($sformatf("tbl%0d_avail", k), 32'(bus4.out_vc_available), 32'(tbl[k].e_avail));
      check($sformatf("tbl%0d_cnt", k),   32'(bus4.credit_cnt_flat), 32'(tbl[k].e_flat));
      check($sformatf("tbl%0d_ready", k), 32'(bus4.out_vc_ready), 32'hf);
      check($sformatf("tbl%0d_ovf", k),   32'(bus4.err_overflow), 32'(tbl[k].e_ovf));
    end

    // A credit still in flight when reset hits must be dropped.
    step(1'b0, 0, 0, 4'b0001, 4'b0000);
    do_reset();
    step(1'b0, 0, 0, 4'b0000, 4'b0000);
    check("rst_drop_cnt", 32'(bus4.credit_cnt_flat), 32'h8888);
    check("rst_drop_ovf", 32'(bus4.err_overflow), 32'h0);

    // Drain VC1 completely, then one flit too many.
    step(1'b0, 0, 0, 4'b0000, 4'b0010);
    step(1'b1, 1, 0, 4'b0000, 4'b0000);
    for (int k = 0; k < 7; k++) step(1'b1, 1, 1, 4'b0000, 4'b0000);
    check("drain_cnt",   32'(bus4.credit_cnt_flat), 32'h8808);
    check("drain_ready", 32'(bus4.out_vc_ready), 32'hd);
    check("drain_unf0",  32'(bus4.err_underflow), 32'h0);
    step(1'b1, 1, 1, 4'b0000, 4'b0000);
    check("under_cnt", 32'(bus4.credit_cnt_flat), 32'h8808);
    check("under_unf", 32'(bus4.err_underflow), 32'h1);

    // Send on a free VC2, then registered credit latency and cancellation.
    step(1'b1, 2, 1, 4'b0000, 4'b0000);
    check("free_send_cnt",   32'(bus4.credit_cnt_flat), 32'h8708);
    check("free_send_avail", 32'(bus4.out_vc_available), 32'hd);
    step(1'b0, 0, 0, 4'b0100, 4'b0000);
    check("cu_lat1", 32'(bus4.credit_cnt_flat), 32'h8708);
    step(1'b0, 0, 0, 4'b0000, 4'b0000);
    check("cu_lat2", 32'(bus4.credit_cnt_flat), 32'h8808);
    step(1'b0, 0, 0, 4'b0100, 4'b0000);
    step(1'b1, 2, 1, 4'b0000, 4'b0000);
    check("cu_cancel", 32'(bus4.credit_cnt_flat), 32'h8808);

    // Claim racing a release, and head+tail releasing a reserved VC.
    step(1'b0, 0, 0, 4'b0000, 4'b1000);
    step(1'b1, 3, 0, 4'b0000, 4'b0000);
    step(1'b1, 3, 2, 4'b0000, 4'b1000);
    check("claim_tail_avail", 32'(bus4.out_vc_available), 32'h5);
    step(1'b0, 0, 0, 4'b0000, 4'b0001);
    check("claim0_avail", 32'(bus4.out_vc_available), 32'h4);
    step(1'b1, 0, 3, 4'b0000, 4'b0000);
    check("ht_release_avail", 32'(bus4.out_vc_available), 32'h5);
    check("ht_release_cnt",   32'(bus4.credit_cnt_flat), 32'h6807);

    // Three-VC instance: id 3 is out of range; unregistered credits.
    step3(1'b1, 3, 0, 3'b000, 3'b000);
    check("oor_cnt",   32'(bus3.credit_cnt_flat), 32'h888);
    check("oor_avail", 32'(bus3.out_vc_available), 32'h7);
    step3(1'b0, 0, 0, 3'b000, 3'b100);
    step3(1'b1, 3, 2, 3'b000, 3'b000);
    check("oor_state", 32'(bus3.out_vc_available), 32'h3);
    check("oor_cnt2",  32'(bus3.credit_cnt_flat), 32'h888);
    step3(1'b1, 0, 1, 3'b000, 3'b000);
    check("direct_dec", 32'(bus3.credit_cnt_flat), 32'h887);
    step3(1'b0, 0, 0, 3'b001, 3'b000);
    check("direct_inc", 32'(bus3.credit_cnt_flat), 32'h888);
    check("direct_err", 32'({bus3.err_overflow, bus3.err_underflow}), 32'h0);
    bus3.credit_upd = '0;

    // Random traffic against the model, with periodic resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 0) do_reset();
      r  = int'($urandom_range(0, 7));
      cu = (r < 4) ? 4'(1 << r) : 4'b0000;
      cl = 4'($urandom & $urandom & $urandom);
      step($urandom_range(0, 9) < 6, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), cu, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
